// File: rtl/playbus_ctrl_if.sv
// PlayBus command port: request fields from the issuer, handshake and
// completion pulses back from the controller.
interface playbus_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_digit;
    logic              cmd_ready;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_digit,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_digit,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/playbus_ctrl.sv
// PlayBus transfer controller: sequences one switch/RAM/ROM -> RAM/LED
// transfer per command over a shared bus and drives seven-segment digits.
//
// state | meaning
// IDLE  | ready for a command
// SRC   | source enabled onto bus, bus captured at end of cycle
// DST   | source still enabled, destination strobed, write at end of cycle
// ERR   | rejected command, one-cycle err pulse
module playbus_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int NDISP  = 2
) (
    input  logic                   n_clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      sw,
    playbus_ctrl_if.slave          cmd,
    output logic                   RAMO,
    output logic                   ROMO,
    output logic                   SWBEN,
    output logic                   RAMW,
    output logic                   LEDLTCH,
    output logic [DATA_W-1:0]      bus,
    output logic [NDISP-1:0][6:0]  disp
);

    typedef enum logic [1:0] {IDLE, SRC, DST, ERR} state_t;

    localparam logic [1:0] OP_SW_RAM  = 2'b00;
    localparam logic [1:0] OP_RAM_LED = 2'b01;
    localparam logic [1:0] OP_ROM_LED = 2'b10;

    state_t state, state_nx;

    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        digit_q;
    logic [DATA_W-1:0] hold;
    logic [3:0]        latch [NDISP];
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_val;
    logic              accept;
    logic              reject;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign accept = (state == IDLE) && cmd.cmd_valid;
    assign reject = (cmd.cmd_op != OP_SW_RAM) && (int'(cmd.cmd_digit) >= NDISP);

    // 3*a mod 2^DATA_W only depends on a mod 2^DATA_W, so work at bus width.
    assign rom_addr = DATA_W'(addr_q);
    assign rom_val  = (rom_addr << 1) + rom_addr;

    always_ff @(posedge n_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = reject ? ERR : SRC;
            SRC:     state_nx = DST;
            DST:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        cmd.done      = 1'b0;
        cmd.err       = 1'b0;
        SWBEN         = 1'b0;
        RAMO          = 1'b0;
        ROMO          = 1'b0;
        RAMW          = 1'b0;
        LEDLTCH       = 1'b0;
        if (state == SRC || state == DST) begin
            SWBEN = (op_q == OP_SW_RAM) || (op_q == 2'b11);
            RAMO  = (op_q == OP_RAM_LED);
            ROMO  = (op_q == OP_ROM_LED);
        end
        if (state == DST) begin
            RAMW     = (op_q == OP_SW_RAM);
            LEDLTCH  = (op_q != OP_SW_RAM);
            cmd.done = 1'b1;
        end
        if (state == ERR) begin
            cmd.err = 1'b1;
        end
    end

    always_comb begin
        bus = '0;
        if (SWBEN) bus = sw;
        if (RAMO)  bus = ram[addr_q];
        if (ROMO)  bus = rom_val;
    end

    always_ff @(posedge n_clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            digit_q <= '0;
            hold    <= '0;
            for (int i = 0; i < NDISP; i++) latch[i] <= '0;
        end else begin
            if (accept) begin
                op_q    <= cmd.cmd_op;
                addr_q  <= cmd.cmd_addr;
                digit_q <= cmd.cmd_digit;
            end
            if (state == SRC) hold <= bus;
            // Only the low nibble is ever displayed, so only that is latched.
            if (LEDLTCH) begin
                for (int i = 0; i < NDISP; i++) begin
                    if (digit_q == 3'(i)) latch[i] <= hold[3:0];
                end
            end
        end
    end

    // RAM keeps its contents through reset; reset forces IDLE so RAMW drops.
    always_ff @(posedge n_clk) begin
        if (RAMW) ram[addr_q] <= hold;
    end

    always_comb begin
        for (int i = 0; i < NDISP; i++) disp[i] = hex7(latch[i]);
    end

endmodule

// File: tb/tb_playbus_ctrl.sv
// Self-checking bench for playbus_ctrl: timeline model of each transfer
// checked every cycle, plus literal display expectations.
module tb_playbus_ctrl;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int ND = 2;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic              n_clk = 1'b0;
    logic              reset = 1'b0;
    logic [DW-1:0]     sw = '0;
    logic              RAMO, ROMO, SWBEN, RAMW, LEDLTCH;
    logic [DW-1:0]     bus;
    logic [ND-1:0][6:0] disp;

    playbus_ctrl_if #(.ADDR_W(AW)) cmd ();

    playbus_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NDISP(ND)) dut (
        .n_clk   (n_clk),
        .reset   (reset),
        .sw      (sw),
        .cmd     (cmd),
        .RAMO    (RAMO),
        .ROMO    (ROMO),
        .SWBEN   (SWBEN),
        .RAMW    (RAMW),
        .LEDLTCH (LEDLTCH),
        .bus     (bus),
        .disp    (disp)
    );

    always #5 n_clk = ~n_clk;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transfer is a timeline counted from its accept edge.
    // age 0 = first cycle after accept, age 1 = second; -1 = no transfer.
    logic [DW-1:0] ram_m [1<<AW];
    logic [3:0]    latch_m [ND];
    int            age = -1;
    logic [1:0]    m_op = 2'b00;
    logic [AW-1:0] m_addr = '0;
    logic [2:0]    m_digit = '0;
    logic          m_rej = 1'b0;
    logic [DW-1:0] m_cap = '0;

    initial for (int i = 0; i < ND; i++) latch_m[i] = 4'h0;

    function automatic logic [DW-1:0] src_val();
        case (m_op)
            2'b01:   return ram_m[m_addr];
            2'b10:   return DW'((3 * int'(m_addr)) % (1 << DW));
            default: return sw;
        endcase
    endfunction

    always @(posedge n_clk or posedge reset) begin
        if (reset) begin
            age = -1;
            for (int i = 0; i < ND; i++) latch_m[i] = 4'h0;
        end else begin
            if (age == 0 && !m_rej) m_cap = src_val();
            if (age == 1 && !m_rej) begin
                if (m_op == 2'b00) ram_m[m_addr] = m_cap;
                else latch_m[int'(m_digit)] = m_cap[3:0];
            end
            if (age >= 0) begin
                age++;
                if (age == (m_rej ? 1 : 2)) age = -1;
            end else if (cmd.cmd_valid) begin
                m_op    = cmd.cmd_op;
                m_addr  = cmd.cmd_addr;
                m_digit = cmd.cmd_digit;
                m_rej   = (cmd.cmd_op != 2'b00) && (int'(cmd.cmd_digit) >= ND);
                age     = 0;
            end
        end
    end

    always @(negedge n_clk) begin
        bit en;
        if (started) begin
            en = (age >= 0) && !m_rej;
            chk("cmd_ready", cmd.cmd_ready, age < 0);
            chk("SWBEN", SWBEN, en && (m_op == 2'b00 || m_op == 2'b11));
            chk("RAMO", RAMO, en && m_op == 2'b01);
            chk("ROMO", ROMO, en && m_op == 2'b10);
            chk("RAMW", RAMW, en && age == 1 && m_op == 2'b00);
            chk("LEDLTCH", LEDLTCH, en && age == 1 && m_op != 2'b00);
            chk("done", cmd.done, en && age == 1);
            chk("err", cmd.err, age == 0 && m_rej);
            chk("bus", bus, en ? src_val() : '0);
            for (int i = 0; i < ND; i++) chk("disp", disp[i], HEX[latch_m[i]]);
            chk("one_source", $countones({RAMO, ROMO, SWBEN}) <= 1, 1'b1);
        end
    end

    // Caller enters just after a falling edge; returns on a falling edge with cmd_ready high.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [2:0] d, input logic [DW-1:0] s);
        int n;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_addr  = a;
        cmd.cmd_digit = d;
        sw            = s;
        @(negedge n_clk);
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b11;
        cmd.cmd_digit = 3'd7;
        @(negedge n_clk);
        sw = ~s;
        n = 0;
        while (!cmd.cmd_ready && n < 10) begin
            @(negedge n_clk);
            n++;
        end
        chk("ready_wait", n < 10, 1'b1);
    endtask

    initial begin
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_addr  = '0;
        cmd.cmd_digit = '0;
        #1 reset = 1'b1;
        #20;
        @(negedge n_clk);
        reset = 1'b0;
        #1;
        chk("rst_disp0", disp[0], 7'b1000000);
        chk("rst_disp1", disp[1], 7'b1000000);
        chk("rst_ready", cmd.cmd_ready, 1'b1);
        chk("rst_bus", bus, 4'h0);
        chk("rst_strobes", {RAMO, ROMO, SWBEN, RAMW, LEDLTCH}, 5'b0);
        started = 1;

        issue(2'b11, 4'd0, 3'd0, 4'hA);
        chk("sw_led_d0", disp[0], 7'b0001000);
        chk("sw_led_d1", disp[1], 7'b1000000);

        issue(2'b00, 4'd3, 3'd0, 4'h5);
        issue(2'b01, 4'd3, 3'd1, 4'h0);
        chk("ram_led_d1", disp[1], 7'b0010010);

        issue(2'b10, 4'd7, 3'd0, 4'h0);
        chk("rom7_d0", disp[0], 7'b0010010);
        issue(2'b10, 4'd15, 3'd0, 4'h0);
        chk("rom15_d0", disp[0], 7'b0100001);

        issue(2'b01, 4'd0, 3'd2, 4'h0);
        chk("err_d0", disp[0], 7'b0100001);
        chk("err_d1", disp[1], 7'b0010010);

        issue(2'b00, 4'd4, 3'd0, 4'h1);
        // SW->RAM addr 4 with 9, reset dropped in during its DST cycle
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_addr  = 4'd4;
        cmd.cmd_digit = 3'd0;
        sw            = 4'h9;
        @(posedge n_clk);
        @(negedge n_clk);
        cmd.cmd_valid = 1'b0;
        @(posedge n_clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_RAMW", RAMW, 1'b0);
        chk("rst_mid_SWBEN", SWBEN, 1'b0);
        chk("rst_mid_ready", cmd.cmd_ready, 1'b1);
        @(negedge n_clk);
        #2 reset = 1'b0;
        chk("rst_mid_d0", disp[0], 7'b1000000);
        chk("rst_mid_d1", disp[1], 7'b1000000);
        @(negedge n_clk);
        issue(2'b01, 4'd4, 3'd0, 4'h0);
        chk("ram4_kept", disp[0], 7'b1111001);

        issue(2'b11, 4'd0, 3'd1, 4'hE);
        chk("sw_led_E", disp[1], 7'b0000110);
        issue(2'b00, 4'd9, 3'd0, 4'hC);
        issue(2'b01, 4'd9, 3'd0, 4'h0);
        chk("ram9_d0", disp[0], 7'b1000110);

        @(negedge n_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
